// File: rtl/bsr_pkg.sv
// Shared definitions for the BSR block scheduler and the sparse array that consumes its issues.
// Holds the scheduler state encoding, the metadata-select encoding and a saturating counter helper.
package bsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_PTR0,
    RD_PTR,
    RD_COL,
    ISSUE,
    DRAIN,
    FINISH
  } sched_state_e;

  typedef enum logic {
    META_ROW_PTR = 1'b0,
    META_COL_IDX = 1'b1
  } meta_sel_e;

  localparam int CNT_W = 32;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down counter of blocks issued but not yet retired, with a hard ceiling.
// A retire with nothing outstanding is ignored so the count can never wrap below zero.
module credit_counter #(
  parameter int MAX_COUNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(MAX_COUNT + 1);

  logic [CW-1:0] count;
  logic          dec_ok;

  assign dec_ok = dec && (count != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({inc, dec_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(MAX_COUNT));
  assign empty = (count == '0);

endmodule

// File: rtl/bsr_block_scheduler.sv
// Walks a block-sparse row layer: reads row_ptr/col_idx metadata and issues one block at a time
// to the sparse array, throttled by a credit limit on blocks still in flight.
module bsr_block_scheduler
  import bsr_pkg::*;
#(
  parameter int IDX_W           = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] num_block_rows,
  output logic             meta_rd_en,
  output logic             meta_sel,
  output logic [IDX_W-1:0] meta_addr,
  input  logic [IDX_W-1:0] meta_rd_data,
  output logic             blk_valid,
  output logic [IDX_W-1:0] blk_row,
  output logic [IDX_W-1:0] blk_col,
  output logic [IDX_W-1:0] blk_ptr,
  input  logic             blk_ready,
  input  logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      blocks_issued,
  output logic [31:0]      empty_rows
);

  sched_state_e state, state_nxt;
  logic         rd_phase, rd_phase_nxt;  // 0: request cycle, 1: data-capture cycle

  logic             start_q;
  logic [IDX_W-1:0] nbr_q;
  logic             abort_q, abort_seen;
  logic [IDX_W-1:0] r_q, ptr_cur_q, ptr_end_q, col_q;
  logic [31:0]      issued_q, empty_q;
  logic             done_q;

  meta_sel_e        sel_c;
  logic [IDX_W-1:0] addr_c;
  logic             rd_en_c;
  logic             accept, ld_ptr0, ld_end, ld_col, row_adv, empty_inc;
  logic             issue_fire, retire, credit_full, credit_empty;
  logic [IDX_W:0]   r_inc, ptr_inc;
  logic             more_rows, more_blks;

  assign abort_seen = abort || abort_q;
  assign r_inc      = {1'b0, r_q} + (IDX_W + 1)'(1);
  assign ptr_inc    = {1'b0, ptr_cur_q} + (IDX_W + 1)'(1);
  assign more_rows  = r_inc < {1'b0, nbr_q};
  assign more_blks  = ptr_inc < {1'b0, ptr_end_q};

  // Once raised, blk_valid cannot fall before the handshake: credits only shrink on issue.
  assign blk_valid  = (state == ISSUE) && !credit_full;
  assign issue_fire = blk_valid && blk_ready;
  assign retire     = res_valid && res_ready;

  credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (issue_fire),
    .dec   (retire),
    .full  (credit_full),
    .empty (credit_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_phase <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_phase <= rd_phase_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    rd_phase_nxt = 1'b0;
    rd_en_c      = 1'b0;
    sel_c        = META_ROW_PTR;
    addr_c       = '0;
    accept       = 1'b0;
    ld_ptr0      = 1'b0;
    ld_end       = 1'b0;
    ld_col       = 1'b0;
    row_adv      = 1'b0;
    empty_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start_q) begin
          accept    = 1'b1;
          state_nxt = (nbr_q == '0) ? FINISH : RD_PTR0;
        end
      end
      RD_PTR0: begin
        if (abort_seen) begin
          state_nxt = DRAIN;
        end else if (!rd_phase) begin
          rd_en_c      = 1'b1;
          rd_phase_nxt = 1'b1;
        end else begin
          ld_ptr0   = 1'b1;
          state_nxt = RD_PTR;
        end
      end
      RD_PTR: begin
        if (abort_seen) begin
          state_nxt = DRAIN;
        end else if (!rd_phase) begin
          rd_en_c      = 1'b1;
          addr_c       = r_inc[IDX_W-1:0];
          rd_phase_nxt = 1'b1;
        end else begin
          ld_end = 1'b1;
          if (meta_rd_data == ptr_cur_q) begin
            empty_inc = 1'b1;
            row_adv   = 1'b1;
            state_nxt = more_rows ? RD_PTR : DRAIN;
          end else begin
            state_nxt = RD_COL;
          end
        end
      end
      RD_COL: begin
        if (abort_seen) begin
          state_nxt = DRAIN;
        end else if (!rd_phase) begin
          rd_en_c      = 1'b1;
          sel_c        = META_COL_IDX;
          addr_c       = ptr_cur_q;
          rd_phase_nxt = 1'b1;
        end else begin
          ld_col    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          if (abort_seen) begin
            state_nxt = DRAIN;
          end else if (more_blks) begin
            state_nxt = RD_COL;
          end else begin
            row_adv   = 1'b1;
            state_nxt = more_rows ? RD_PTR : DRAIN;
          end
        end else if (abort_seen && !blk_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (credit_empty) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start is registered together with the row count; a start seen outside IDLE is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      nbr_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= start && (state == IDLE) && !start_q;
      if (start && (state == IDLE) && !start_q) nbr_q <= num_block_rows;
      if (state == IDLE)  abort_q <= 1'b0;
      else if (abort)     abort_q <= 1'b1;
      done_q <= (state == FINISH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      ptr_cur_q <= '0;
      ptr_end_q <= '0;
      col_q     <= '0;
      issued_q  <= '0;
      empty_q   <= '0;
    end else if (accept) begin
      r_q       <= '0;
      ptr_cur_q <= '0;
      ptr_end_q <= '0;
      col_q     <= '0;
      issued_q  <= '0;
      empty_q   <= '0;
    end else begin
      if (ld_ptr0) begin
        ptr_cur_q <= meta_rd_data;
        r_q       <= '0;
      end
      if (ld_end) ptr_end_q <= meta_rd_data;
      if (ld_col) col_q     <= meta_rd_data;
      // An empty row advances in the same cycle its end pointer arrives, before ptr_end_q updates.
      if (row_adv) begin
        r_q       <= r_inc[IDX_W-1:0];
        ptr_cur_q <= ld_end ? meta_rd_data : ptr_end_q;
      end else if (issue_fire) begin
        ptr_cur_q <= ptr_inc[IDX_W-1:0];
      end
      if (issue_fire) issued_q <= sat_inc(issued_q);
      if (empty_inc)  empty_q  <= sat_inc(empty_q);
    end
  end

  assign meta_rd_en    = rd_en_c;
  assign meta_sel      = sel_c;
  assign meta_addr     = addr_c;
  assign blk_row       = r_q;
  assign blk_col       = col_q;
  assign blk_ptr       = ptr_cur_q;
  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign blocks_issued = issued_q;
  assign empty_rows    = empty_q;

endmodule

// File: tb/tb_bsr_block_scheduler.sv
// Self-checking bench for bsr_block_scheduler: a metadata memory model, a retire generator,
// a layer-walk reference model and one negedge compare process, driven by directed scenarios.
module tb_bsr_block_scheduler;

  localparam int IDX_W = 16;
  localparam int MAXO  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [IDX_W-1:0] num_block_rows = '0;
  logic             meta_rd_en;
  logic             meta_sel;
  logic [IDX_W-1:0] meta_addr;
  logic [IDX_W-1:0] meta_rd_data = 16'hDEAD;
  logic             blk_valid;
  logic [IDX_W-1:0] blk_row, blk_col, blk_ptr;
  logic             blk_ready = 1'b0;
  logic             res_valid = 1'b0;
  logic             res_ready = 1'b0;
  logic             busy, done;
  logic [31:0]      blocks_issued, empty_rows;

  bsr_block_scheduler #(
    .IDX_W           (IDX_W),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .num_block_rows (num_block_rows),
    .meta_rd_en     (meta_rd_en),
    .meta_sel       (meta_sel),
    .meta_addr      (meta_addr),
    .meta_rd_data   (meta_rd_data),
    .blk_valid      (blk_valid),
    .blk_row        (blk_row),
    .blk_col        (blk_col),
    .blk_ptr        (blk_ptr),
    .blk_ready      (blk_ready),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .busy           (busy),
    .done           (done),
    .blocks_issued  (blocks_issued),
    .empty_rows     (empty_rows)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] ptr;
  } blk_t;

  blk_t        exp_q[$];
  blk_t        act_log[$];
  int          retire_due[$];
  logic [15:0] row_ptr_m [0:15];
  logic [15:0] col_idx_m [0:15];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int mdl_out = 0;
  int n_hs = 0;
  int n_done = 0;
  int last_done_cyc = 0;
  int last_hs_cyc = 0;
  int exp_empty = 0;
  int manual_retire = 0;
  bit retire_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Metadata memory: a read requested in cycle t presents its data during cycle t+1 only.
  initial begin : meta_model
    logic        req, sel;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      req = meta_rd_en;
      sel = meta_sel;
      a   = meta_addr;
      @(posedge clk);
      #1;
      if (req) meta_rd_data = sel ? col_idx_m[a[3:0]] : row_ptr_m[a[3:0]];
      else     meta_rd_data = 16'hDEAD;
    end
  end

  // Retires land 10 cycles after each issue; idle cycles toggle half-handshakes that must not count.
  initial begin : retire_gen
    forever begin
      @(posedge clk);
      #2;
      if (manual_retire > 0) begin
        manual_retire--;
        if (retire_due.size() > 0) void'(retire_due.pop_front());
        res_valid = 1'b1;
        res_ready = 1'b1;
      end else if (retire_en && retire_due.size() > 0 && cyc >= retire_due[0]) begin
        void'(retire_due.pop_front());
        res_valid = 1'b1;
        res_ready = 1'b1;
      end else begin
        res_valid = cyc[0];
        res_ready = ~cyc[0];
      end
    end
  end

  // Compare process: every handshake against the model, hold-while-stalled, credit ceiling, done.
  logic prev_stall = 1'b0;
  logic prev_rd = 1'b0;
  blk_t prev_blk;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
      mdl_out    = 0;
      retire_due.delete();
    end else begin
      if (prev_stall) begin
        check("hold_valid", blk_valid, 1);
        check("hold_fields", {blk_row, blk_col, blk_ptr}, prev_blk);
      end
      if (meta_rd_en) check("rd_en_single_cycle", prev_rd, 0);
      if (blk_valid) check("credit_limit", mdl_out < MAXO, 1);
      if (blk_valid && blk_ready) begin
        act_log.push_back({blk_row, blk_col, blk_ptr});
        n_hs++;
        last_hs_cyc = cyc;
        retire_due.push_back(cyc + 10);
        if (exp_q.size() == 0) check("issue_unexpected", 1, 0);
        else                   check("issue", {blk_row, blk_col, blk_ptr}, exp_q.pop_front());
      end
      if (done) begin
        n_done++;
        last_done_cyc = cyc;
        check("done_after_drain", mdl_out, 0);
      end
      if (res_valid && res_ready && mdl_out > 0) mdl_out--;
      if (blk_valid && blk_ready) mdl_out++;
      prev_stall = blk_valid && !blk_ready;
      prev_blk   = {blk_row, blk_col, blk_ptr};
      prev_rd    = meta_rd_en;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Reference walk of the layer straight from the CSR-style row_ptr/col_idx tables.
  task automatic build_expected(input int nbr);
    exp_q.delete();
    exp_empty = 0;
    for (int r = 0; r < nbr; r++) begin
      if (row_ptr_m[r] == row_ptr_m[r+1]) exp_empty++;
      for (int p = int'(row_ptr_m[r]); p < int'(row_ptr_m[r+1]); p++)
        exp_q.push_back({16'(r), col_idx_m[p], 16'(p)});
    end
  endtask

  task automatic load_layer(input int which);
    for (int i = 0; i < 16; i++) begin
      row_ptr_m[i] = '0;
      col_idx_m[i] = '0;
    end
    if (which == 0) begin
      row_ptr_m[0] = 0; row_ptr_m[1] = 2; row_ptr_m[2] = 2; row_ptr_m[3] = 3;
      col_idx_m[0] = 5; col_idx_m[1] = 1; col_idx_m[2] = 7;
    end else begin
      row_ptr_m[0] = 0; row_ptr_m[1] = 4;
      col_idx_m[0] = 3; col_idx_m[1] = 9; col_idx_m[2] = 2; col_idx_m[3] = 6;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int nbr);
    num_block_rows = IDX_W'(nbr);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0 = n_done;
    int k  = 0;
    while (n_done == n0 && k < budget) begin
      tick();
      k++;
    end
    check({name, "_done_seen"}, n_done > n0, 1);
  endtask

  task automatic wait_first_issue(input int h0, input int budget);
    int k = 0;
    while (n_hs == h0 && k < budget) begin
      tick();
      k++;
    end
    check("first_issue_seen", n_hs > h0, 1);
  endtask

  initial begin : main
    int   h0, d0, t0, k;
    blk_t snap;

    load_layer(0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_blk_valid", blk_valid, 0);
    check("reset_meta_rd_en", meta_rd_en, 0);
    check("reset_blocks_issued", blocks_issued, 0);
    check("reset_empty_rows", empty_rows, 0);

    // Basic layer pass, plus a start pulse while busy that must be ignored.
    build_expected(3);
    check("model_len", exp_q.size(), 3);
    check("model_blk0", exp_q[0], {16'd0, 16'd5, 16'd0});
    check("model_blk2", exp_q[2], {16'd2, 16'd7, 16'd2});
    check("model_empty", exp_empty, 1);
    blk_ready = 1'b1;
    h0 = n_hs;
    d0 = n_done;
    act_log.delete();
    pulse_start(3);
    tick(4);
    pulse_start(7);
    wait_done("pass1", 300);
    tick(5);
    check("pass1_issues", n_hs - h0, 3);
    check("pass1_issue0", act_log[0], {16'd0, 16'd5, 16'd0});
    check("pass1_issue1", act_log[1], {16'd0, 16'd1, 16'd1});
    check("pass1_issue2", act_log[2], {16'd2, 16'd7, 16'd2});
    check("pass1_blocks_issued", blocks_issued, 3);
    check("pass1_empty_rows", empty_rows, 1);
    check("pass1_done_pulses", n_done - d0, 1);
    check("pass1_model_consumed", exp_q.size(), 0);

    // Back-pressure: the first block must sit unchanged on the port for 20 cycles.
    blk_ready = 1'b0;
    build_expected(3);
    h0 = n_hs;
    pulse_start(3);
    k = 0;
    while (!blk_valid && k < 50) begin
      tick();
      k++;
    end
    check("stall_valid_seen", blk_valid, 1);
    snap = {blk_row, blk_col, blk_ptr};
    tick(20);
    check("stall_still_valid", blk_valid, 1);
    check("stall_fields", {blk_row, blk_col, blk_ptr}, snap);
    check("stall_fields_literal", snap, {16'd0, 16'd5, 16'd0});
    check("stall_no_issue", n_hs - h0, 0);
    blk_ready = 1'b1;
    wait_done("pass2", 300);
    check("pass2_issues", n_hs - h0, 3);

    // Spurious retire while nothing is outstanding, then withhold retires at the credit limit.
    tick(20);
    manual_retire = 1;
    tick(3);
    load_layer(1);
    retire_en = 1'b0;
    build_expected(1);
    h0 = n_hs;
    pulse_start(1);
    tick(40);
    check("withhold_issues", n_hs - h0, 2);
    check("withhold_valid_low", blk_valid, 0);
    check("withhold_busy", busy, 1);
    manual_retire = 1;
    tick(8);
    check("one_retire_issues", n_hs - h0, 3);
    retire_en = 1'b1;
    wait_done("pass3", 300);
    check("pass3_blocks_issued", blocks_issued, 4);
    check("pass3_empty_rows", empty_rows, 0);

    // Zero-row layer: done three cycles after start, nothing issued, counters cleared.
    tick(5);
    h0 = n_hs;
    num_block_rows = '0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    wait_done("zero", 20);
    check("zero_latency", last_done_cyc - t0, 3);
    check("zero_issues", n_hs - h0, 0);
    check("zero_blocks_issued", blocks_issued, 0);
    check("zero_empty_rows", empty_rows, 0);

    // Abort right after the first issue: no more issues, done only after that block retires.
    load_layer(0);
    build_expected(3);
    tick(5);
    h0 = n_hs;
    pulse_start(3);
    wait_first_issue(h0, 50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abort", 100);
    tick(5);
    check("abort_issues", n_hs - h0, 1);
    check("abort_blocks_issued", blocks_issued, 1);
    check("abort_done_after_retire", (last_done_cyc - last_hs_cyc) > 10, 1);
    exp_q.delete();

    // Reset in the middle of ISSUE with a second block stalled on the port.
    tick(5);
    build_expected(3);
    h0 = n_hs;
    pulse_start(3);
    wait_first_issue(h0, 50);
    blk_ready = 1'b0;
    k = 0;
    while (!blk_valid && k < 20) begin
      tick();
      k++;
    end
    check("pre_reset_valid", blk_valid, 1);
    check("pre_reset_blocks_issued", blocks_issued, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_blk_valid", blk_valid, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_blocks_issued", blocks_issued, 0);
    check("mid_reset_empty_rows", empty_rows, 0);
    check("mid_reset_blk_ptr", blk_ptr, 0);
    check("mid_reset_meta_rd_en", meta_rd_en, 0);
    tick(3);
    rst_n = 1'b1;
    blk_ready = 1'b1;
    exp_q.delete();
    h0 = n_hs;
    tick(15);
    check("post_reset_idle", busy, 0);
    check("post_reset_no_issue", n_hs - h0, 0);

    // A fresh start after reset runs a full pass again.
    build_expected(3);
    pulse_start(3);
    wait_done("recover", 300);
    tick(15);
    check("recover_issues", n_hs - h0, 3);
    check("recover_empty_rows", empty_rows, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsr_block_scheduler.md
BSR_BLOCK_SCHEDULER -- requirements
Module: bsr_block_scheduler

Interface
REQ-001 SHALL have parameter IDX_W, default 16, width of row/col/pointer indices.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, limit on blocks issued but not yet retired.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, pulse that launches one layer pass; ignored unless idle.
REQ-006 SHALL have port abort, input, 1, stops the pass at the next safe point.
REQ-007 SHALL have port num_block_rows, input, IDX_W, block rows in the layer; sampled on start.
REQ-008 SHALL have ports meta_rd_en (output, 1), meta_sel (output, 1: 0=row_ptr, 1=col_idx), meta_addr (output, IDX_W), and meta_rd_data (input, IDX_W); the metadata read port.
REQ-009 SHALL have ports blk_valid (output, 1), blk_row (output, IDX_W), blk_col (output, IDX_W), blk_ptr (output, IDX_W: block index into the weight store), and blk_ready (input, 1); the issue port to the sparse array.
REQ-010 SHALL have ports res_valid (input, 1) and res_ready (input, 1); these observe the array result handshake.
REQ-011 SHALL have ports busy (output, 1), done (output, 1: one-cycle pulse), blocks_issued (output, 32), and empty_rows (output, 32).

Function
REQ-012 SHALL implement the states IDLE, RD_PTR0, RD_PTR, RD_COL, ISSUE, DRAIN, and FINISH.
REQ-013 SHALL read metadata with fixed latency: with meta_rd_en high in cycle t, meta_rd_data is valid in cycle t+1.
REQ-014 In IDLE, start with num_block_rows>0 SHALL go to RD_PTR0 and read row_ptr[0].
REQ-015 In IDLE, start with num_block_rows==0 SHALL go directly to FINISH.
REQ-016 RD_PTR0 SHALL latch ptr_cur=row_ptr[0], set r=0, and go to RD_PTR.
REQ-017 RD_PTR SHALL read row_ptr[r+1] and latch ptr_end.
REQ-018 After RD_PTR, if ptr_cur==ptr_end (empty row), the block SHALL increment empty_rows and advance the row (REQ-022) without any issue.
REQ-019 After RD_PTR, if ptr_cur!=ptr_end, the block SHALL go to RD_COL.
REQ-020 RD_COL SHALL read col_idx[ptr_cur], latch it into blk_col, and go to ISSUE.
REQ-021 In ISSUE, blk_valid SHALL be 1 and blk_row=r, blk_col=latched col, blk_ptr=ptr_cur SHALL hold stable until blk_valid&&blk_ready.
REQ-021a On that handshake, blocks_issued and outstanding SHALL increment and ptr_cur SHALL increment.
REQ-021b After the handshake, if ptr_cur+1<ptr_end the block SHALL go to RD_COL; otherwise it SHALL advance the row.
REQ-022 Row advance SHALL set r=r+1 and ptr_cur=ptr_end, then go to RD_PTR if r+1<num_block_rows, else to DRAIN.
REQ-023 blk_valid SHALL be held low while outstanding==MAX_OUTSTANDING.
REQ-024 outstanding SHALL decrement on each cycle with res_valid&&res_ready.
REQ-025 On a simultaneous issue and retire in one cycle, outstanding SHALL remain unchanged.
REQ-026 A retire while outstanding==0 SHALL be ignored and the counter SHALL not wrap.
REQ-027 DRAIN SHALL wait for outstanding==0, then go to FINISH.
REQ-028 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 abort SHALL suppress any new issue, never drop a blk_valid already asserted before its handshake, then go to DRAIN.
REQ-031 start while busy SHALL be ignored.
REQ-032 blocks_issued and empty_rows SHALL clear on an accepted start and otherwise saturate at 2^32-1.
REQ-033 meta_rd_en SHALL assert only in the read states, for exactly one cycle per read.

Reset
REQ-034 rst_n low SHALL force state=IDLE, all counters and latches to 0, and every output to 0, from any state including mid-ISSUE.
REQ-035 After reset deassertion, the block SHALL require a new start before doing anything.

Structure
REQ-036 The state enum and the meta_sel encodings SHALL live in a shared package, bsr_pkg, that the sparse array also imports.
REQ-037 The outstanding up/down counter with limit SHALL be a single sub-module, credit_counter.

Verification
REQ-038 Bench SHALL run row_ptr={0,2,2,3}, col_idx={5,1,7}, num_block_rows=3 with blk_ready=1 and res_valid&&res_ready 10 cycles after each issue; required: issues (0,5,0),(0,1,1),(2,7,2), empty_rows=1, blocks_issued=3, one done pulse.
REQ-039 Bench SHALL hold blk_ready=0 for 20 cycles; required: blk_valid stays 1 and blk_row/blk_col/blk_ptr stay constant.
REQ-040 Bench SHALL withhold all retires for MAX_OUTSTANDING=2; required: exactly 2 issues, then blk_valid=0 until one retire.
REQ-041 Bench SHALL run num_block_rows=0; required: done pulses 3 cycles after start with 0 issues.
REQ-042 Bench SHALL assert abort after the first issue; required: no further issue and done only after the outstanding block retires.
REQ-043 Bench SHALL pulse rst_n low during ISSUE; required: blk_valid=0 and busy=0 immediately, and all counters read 0.
